// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: instruction RAM port, branch redirect input and decoder-facing queue head.
// The master side is the fetch queue; the slave side is the RAM/branch/decoder environment.
interface ifetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_rdata, br_valid, br_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_rdata, br_valid, br_target, instr_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Sequential instruction prefetcher with a DEPTH-entry {pc,data} FIFO between a
// 1-cycle-latency instruction RAM and the decoder; a branch redirect flushes everything.
module ifetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     nreset,
  ifetch_queue_if.master           bus,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              pending_reg;
  logic [ADDR_W-1:0] pend_pc_reg;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              redirect;
  logic              head_valid;
  logic              pop;
  logic              push;
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0]  demand;
  logic [DEPTH-1:0]  wr_en;

  // Reset gates the request path so nothing is issued while nreset is low.
  assign redirect   = bus.br_valid & nreset;
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid & bus.instr_ready;
  assign push       = pending_reg & ~redirect;

  // Slots committed after this cycle; requesting only below DEPTH means a response always fits.
  assign demand   = count_reg + CNT_W'(pending_reg) - CNT_W'(pop);
  assign req      = nreset & (redirect | (demand < CNT_W'(DEPTH)));
  assign req_addr = redirect ? {bus.br_target[ADDR_W-1:2], 2'b00} : fetch_pc_reg;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = req_addr;
  assign bus.instr_valid = head_valid;
  assign bus.instr_data  = data_mem[rd_ptr_reg];
  assign bus.instr_pc    = pc_mem[rd_ptr_reg];
  assign occupancy       = count_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      pending_reg  <= 1'b0;
      pend_pc_reg  <= '0;
      fetch_pc_reg <= RESET_PC;
    end else begin
      if (redirect) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
      pending_reg <= req;
      if (req) begin
        pend_pc_reg  <= req_addr;
        fetch_pc_reg <= req_addr + ADDR_W'(4);
      end
    end
  end

  // Storage is reset so the head reads as zero before the first fill.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          pc_mem[i]   <= pend_pc_reg;
          data_mem[i] <= bus.imem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: stimulus queues expected PCs, a negedge monitor
// checks every popped instruction; RAM model returns word index (addr>>2) one cycle later.
module tb_ifetch_queue;
  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [2:0] occupancy;
  int         n_vec = 0;
  int         n_err = 0;
  int         reqs;
  logic [31:0] exp_q[$];

  ifetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial bus.imem_rdata = '0;
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr >> 2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every accepted head is matched against the expected queue.
  always @(negedge clk) begin
    if (nreset && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %h expected no pop", bus.instr_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        $display("pop pc=%h data=%h (expect pc=%h)", bus.instr_pc, bus.instr_data, epc);
        chk("pop_pc", bus.instr_pc, epc);
        chk("pop_data", bus.instr_data, epc >> 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Leaves the caller at posedge+1 of cycle c0, the first cycle out of reset.
  task automatic do_reset(input logic rdy);
    nreset          = 1'b0;
    bus.br_valid    = 1'b0;
    bus.br_target   = '0;
    bus.instr_ready = rdy;
    repeat (2) @(posedge clk);
    chk("drain", 32'(exp_q.size()), 0);
    exp_q.delete();
    #1 nreset = 1'b1;
  endtask

  initial begin
    bus.br_valid    = 1'b0;
    bus.br_target   = '0;
    bus.instr_ready = 1'b0;

    // 1: reset values, then streaming with ready=1
    nreset = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 32'h100);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_data", bus.instr_data, 0);
    chk("rst_pc", bus.instr_pc, 0);
    chk("rst_occ", 32'(occupancy), 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    push_seq(32'h100, 8);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 6) begin
        chk("t1_req", 32'(bus.imem_req), 1);
        chk("t1_addr", bus.imem_addr, 32'h100 + 32'(4 * c));
      end
      if (c == 1) chk("t1_valid_c1", 32'(bus.instr_valid), 0);
      if (c == 2) chk("t1_valid_c2", 32'(bus.instr_valid), 1);
      step();
    end
    bus.instr_ready = 1'b0;

    // 2: stalled consumer fills to DEPTH, then drains in order and fetch resumes
    do_reset(1'b0);
    push_seq(32'h100, 4);
    reqs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.imem_req) reqs++;
      if (c == 6) begin
        chk("t2_occ_full", 32'(occupancy), 4);
        chk("t2_req_full", 32'(bus.imem_req), 0);
      end
      step();
    end
    chk("t2_reqs", 32'(reqs), 4);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume_req", 32'(bus.imem_req), 1);
    chk("t2_resume_addr", bus.imem_addr, 32'h110);
    repeat (4) step();
    bus.instr_ready = 1'b0;

    // 3: redirect with 3 entries queued
    do_reset(1'b0);
    push_seq(32'h200, 4);
    repeat (4) step();
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h203;
    @(negedge clk);
    chk("t3_occ_before", 32'(occupancy), 3);
    chk("t3_br_req", 32'(bus.imem_req), 1);
    chk("t3_br_addr", bus.imem_addr, 32'h200);
    step();
    bus.br_valid    = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("t3_occ_n1", 32'(occupancy), 0);
    chk("t3_valid_n1", 32'(bus.instr_valid), 0);
    step();
    @(negedge clk);
    chk("t3_valid_n2", 32'(bus.instr_valid), 1);
    chk("t3_pc_n2", bus.instr_pc, 32'h200);
    repeat (4) step();
    bus.instr_ready = 1'b0;

    // 4: back-to-back redirects, last target wins
    do_reset(1'b0);
    step();
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h40;
    step();
    bus.br_target = 32'h80;
    @(negedge clk);
    chk("t4_addr", bus.imem_addr, 32'h80);
    step();
    bus.br_valid    = 1'b0;
    bus.instr_ready = 1'b1;
    push_seq(32'h80, 4);
    @(negedge clk);
    chk("t4_occ", 32'(occupancy), 0);
    repeat (5) step();
    bus.instr_ready = 1'b0;

    // 5: fetch address wraps past the top of memory
    do_reset(1'b0);
    bus.br_valid    = 1'b1;
    bus.br_target   = 32'hFFFF_FFF8;
    bus.instr_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    @(negedge clk);
    chk("t5_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    step();
    bus.br_valid = 1'b0;
    @(negedge clk);
    chk("t5_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("t5_addr2", bus.imem_addr, 32'h0000_0000);
    repeat (4) step();
    bus.instr_ready = 1'b0;

    // 6: asynchronous reset with data queued and a fetch in flight
    do_reset(1'b0);
    repeat (4) step();
    @(negedge clk);
    chk("t6_occ_before", 32'(occupancy), 3);
    #2 nreset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.instr_valid), 0);
    chk("t6_async_occ", 32'(occupancy), 0);
    chk("t6_async_req", 32'(bus.imem_req), 0);
    repeat (2) @(posedge clk);
    chk("t6_drain", 32'(exp_q.size()), 0);
    push_seq(32'h100, 4);
    #1 nreset = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("t6_restart_addr", bus.imem_addr, 32'h100);
    repeat (6) step();
    bus.instr_ready = 1'b0;

    repeat (3) step();
    chk("final_drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
